bsg_tag_packet_tx: RTL and testbench

Synthesizable bsg_tag packet transmitter. It accepts one parallel tag command per handshake: destination node ID, data_not_reset flag, payload length and payload. It serializes the command onto the single-bit bsg_tag line consumed by bsg_tag_master. It replaces ROM-driven trace replay wherever on-chip logic (boot FSM, host bridge) must program bsg_tag clients.

---
 rtl/bsg_tag_pkg.sv | 27 ++
 rtl/bsg_tag_tx_shifter.sv | 23 ++
 rtl/bsg_tag_packet_tx.sv | 98 +++++++++
 tb/tb_bsg_tag_packet_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bsg_tag_pkg.sv
// bsg_tag_pkg: shared FSM state type, sizing helpers and header layout for the tag transmitter
package bsg_tag_pkg;

    typedef enum logic [2:0] {e_idle, e_start, e_hdr, e_pay, e_gap} bsg_tag_tx_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int width_for(input int x);
        return (x <= 1) ? 1 : $clog2(x + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

`ifndef DECLARE_BSG_TAG_HEADER_S
`define DECLARE_BSG_TAG_HEADER_S(id_width_mp, lg_width_mp) \
    typedef struct packed { \
        logic [lg_width_mp-1:0] len; \
        logic data_not_reset; \
        logic [id_width_mp-1:0] nodeID; \
    } bsg_tag_header_s
`endif

// File: rtl/bsg_tag_tx_shifter.sv
// bsg_tag_tx_shifter: loadable LSB-first parallel-in serial-out register
module bsg_tag_tx_shifter #(
    parameter int width_p = 22
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    input  logic               shift_i,
    output logic               data_o
);

    logic [width_p-1:0] sr;

    // load wins over shift; zeros fill from the top
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) sr <= '0;
        else if (load_i) sr <= data_i;
        else if (shift_i) sr <= {1'b0, sr[width_p-1:1]};

    assign data_o = sr[0];

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// bsg_tag_packet_tx: serializes one parallel tag command onto the single-bit bsg_tag line
module bsg_tag_packet_tx
    import bsg_tag_pkg::*;
#(
    parameter int els_p      = 3,
    parameter int lg_width_p = 4,
    parameter int gap_p      = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    output logic                           ready_and_o,
    input  logic [safe_clog2(els_p)-1:0]   node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_p-1:0]          len_i,
    input  logic [(1 << lg_width_p)-2:0]   payload_i,
    output logic                           tag_data_o,
    output logic                           busy_o
);

    localparam int id_width  = safe_clog2(els_p);
    localparam int hdr_width = id_width + 1 + lg_width_p;
    localparam int pay_width = (1 << lg_width_p) - 1;
    localparam int ctr_width = width_for(max3(hdr_width, pay_width, gap_p));
    localparam logic [ctr_width-1:0] hdr_last = ctr_width'(hdr_width - 1);
    localparam logic [ctr_width-1:0] gap_last = ctr_width'(gap_p - 1);

    `DECLARE_BSG_TAG_HEADER_S(id_width, lg_width_p);

    bsg_tag_header_s        hdr;
    bsg_tag_tx_state_e      state;
    logic [ctr_width-1:0]   ctr;
    logic [lg_width_p-1:0]  len_r;
    logic                   sr_bit, load, shift, pay_last;

    assign hdr         = {len_i, data_not_reset_i, node_id_i};
    assign ready_and_o = state == e_idle;
    assign busy_o      = state != e_idle;
    assign load        = ready_and_o & v_i;
    assign shift       = state inside {e_start, e_hdr, e_pay};
    assign pay_last    = (ctr + ctr_width'(1)) == ctr_width'(len_r);

    bsg_tag_tx_shifter #(.width_p(hdr_width + pay_width)) shifter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .load_i   (load),
        .data_i   ({payload_i, hdr}),
        .shift_i  (shift),
        .data_o   (sr_bit)
    );

    // the line flop is loaded with the bit for the state being entered, so it is valid for the whole cycle
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state      <= e_idle;
            ctr        <= '0;
            len_r      <= '0;
            tag_data_o <= 1'b0;
        end else begin
            case (state)
                e_idle: if (v_i) begin
                    state      <= e_start;
                    len_r      <= hdr.len;
                    tag_data_o <= 1'b1;
                end
                e_start: begin
                    state      <= e_hdr;
                    ctr        <= '0;
                    tag_data_o <= sr_bit;
                end
                e_hdr: if (ctr == hdr_last) begin
                    state      <= (len_r != '0) ? e_pay : e_gap;
                    ctr        <= '0;
                    tag_data_o <= (len_r != '0) & sr_bit;
                end else begin
                    ctr        <= ctr + ctr_width'(1);
                    tag_data_o <= sr_bit;
                end
                e_pay: if (pay_last) begin
                    state      <= e_gap;
                    ctr        <= '0;
                    tag_data_o <= 1'b0;
                end else begin
                    ctr        <= ctr + ctr_width'(1);
                    tag_data_o <= sr_bit;
                end
                e_gap: begin
                    tag_data_o <= 1'b0;
                    if (ctr == gap_last) begin
                        state <= e_idle;
                        ctr   <= '0;
                    end else ctr <= ctr + ctr_width'(1);
                end
                default: state <= e_idle;
            endcase
        end

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// tb_bsg_tag_packet_tx: scoreboard bench checking the serial bsg_tag bit stream bit by bit
module tb_bsg_tag_packet_tx;

    localparam int GAP = 2;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_and_o;
    logic [1:0]  node_id_i;
    logic        data_not_reset_i;
    logic [3:0]  len_i;
    logic [14:0] payload_i;
    logic        tag_data_o;
    logic        busy_o;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    logic exp_q[$];

    bsg_tag_packet_tx #(.els_p(3), .lg_width_p(4), .gap_p(GAP)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .v_i             (v_i),
        .ready_and_o     (ready_and_o),
        .node_id_i       (node_id_i),
        .data_not_reset_i(data_not_reset_i),
        .len_i           (len_i),
        .payload_i       (payload_i),
        .tag_data_o      (tag_data_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected serial image of one command, including the trailing gap zeros
    task automatic push_pkt(input logic [1:0] id, input logic dnr, input logic [3:0] len, input logic [14:0] pay);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 2; i++) exp_q.push_back(id[i]);
        exp_q.push_back(dnr);
        for (int i = 0; i < 4; i++) exp_q.push_back(len[i]);
        for (int i = 0; i < 15; i++) if (i < int'(len)) exp_q.push_back(pay[i]);
        for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_and_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_and_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready_and_o still %0b after %0d cycles", ready_and_o, n);
        end
    endtask

    task automatic send(input logic [1:0] id, input logic dnr, input logic [3:0] len, input logic [14:0] pay);
        int n = 0;
        wait_ready();
        push_pkt(id, dnr, len, pay);
        node_id_i = id;
        data_not_reset_i = dnr;
        len_i = len;
        payload_i = pay;
        v_i = 1'b1;
        @(posedge clk_i);
        #1 v_i = 1'b0;
        payload_i = 15'h2AAA;
        len_i = 4'hF;
        while (!ready_and_o && n < 100) begin
            @(posedge clk_i);
            #1 n++;
        end
        check("packet_cycles", n, 10 + int'(len));
        check("drained", exp_q.size(), 0);
    endtask

    // monitor: every busy cycle must present the next expected bit; idle line must be low
    always @(negedge clk_i)
        if (mon_en && reset_n_i) begin
            if (busy_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_bit: busy with nothing expected, line %0b", tag_data_o);
                end else check("bit", tag_data_o, exp_q.pop_front());
            end else check("idle_line", tag_data_o, 1'b0);
            check("ready_vs_busy", ready_and_o, !busy_o);
        end

    initial begin
        reset_n_i = 1'b0;
        v_i = 1'b0;
        node_id_i = '0;
        data_not_reset_i = 1'b0;
        len_i = '0;
        payload_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) reset_n_i = 1'b1;
        #1;
        check("reset_tag", tag_data_o, 1'b0);
        check("reset_ready", ready_and_o, 1'b1);
        check("reset_busy", busy_o, 1'b0);
        mon_en = 1'b1;

        send(2'd1, 1'b1, 4'd7, 15'h0055);
        send(2'd2, 1'b0, 4'd0, 15'h0000);

        // back-to-back with v_i held high
        push_pkt(2'd0, 1'b1, 4'd4, 15'h000A);
        node_id_i = 2'd0; data_not_reset_i = 1'b1; len_i = 4'd4; payload_i = 15'h000A;
        v_i = 1'b1;
        wait_ready();
        @(posedge clk_i);
        #1 push_pkt(2'd1, 1'b1, 4'd1, 15'h0001);
        node_id_i = 2'd1; len_i = 4'd1; payload_i = 15'h0001;
        wait_ready();
        @(posedge clk_i);
        #1 push_pkt(2'd2, 1'b1, 4'd2, 15'h0002);
        node_id_i = 2'd2; len_i = 4'd2; payload_i = 15'h0002;
        wait_ready();
        @(posedge clk_i);
        #1 v_i = 1'b0;
        @(negedge clk_i);
        wait_ready();
        @(negedge clk_i);
        check("b2b_drained", exp_q.size(), 0);

        // reset while shifting payload bit 2 (a one)
        push_pkt(2'd1, 1'b1, 4'd7, 15'h0055);
        node_id_i = 2'd1; data_not_reset_i = 1'b1; len_i = 4'd7; payload_i = 15'h0055;
        v_i = 1'b1;
        @(posedge clk_i);
        #1 v_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 check("pre_reset_tag", tag_data_o, 1'b1);
        #1 reset_n_i = 1'b0;
        #1;
        check("midreset_tag", tag_data_o, 1'b0);
        check("midreset_busy", busy_o, 1'b0);
        check("midreset_ready", ready_and_o, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        send(2'd1, 1'b0, 4'd0, 15'h0000);
        send(2'd1, 1'b1, 4'd7, 15'h0055);

        // max length, then short length with garbage above len
        send(2'd2, 1'b1, 4'd15, 15'h7FFF);
        send(2'd2, 1'b1, 4'd3, 15'h7FF5);
        send(2'd0, 1'b1, 4'd5, 15'h5A53);

        repeat (3) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
